// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: command sequencer for a 4-bit 74194-style universal shift register.
// It accepts one command per valid/ready transfer. It then drives the register's mode
// (S), its parallel data (PData) and its serial inputs (SR/SL) to carry out one of four
// operations: a load, an N-step shift right, an N-step shift left, or a left-then-right
// bounce. Steps are spaced TICK_DIV clocks apart.
module shift_reg_ctrl #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [3:0] cmd_count,
  input  logic       cmd_fill,
  input  logic       cmd_fill_bit,
  input  logic [3:0] Q,
  output logic [1:0] S,
  output logic [3:0] PData,
  output logic       SR,
  output logic       SL,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StFinish} state_e;

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_op;
  logic [3:0]       r_count;
  logic             r_fill, r_fill_bit;
  logic [TickW-1:0] r_tick, w_tick_nxt;
  logic [4:0]       r_step, w_step_nxt;
  logic [1:0]       w_s_nxt, w_run_dir;
  logic [3:0]       w_pdata_nxt;
  logic [4:0]       w_total;
  logic             w_accept, w_tick_term;

  // Handshake, status outputs and the step bookkeeping for the running command
  always_comb begin
    cmd_ready   = ((r_state == StIdle) || (r_state == StFinish)) && !clear;
    w_accept    = cmd_valid && cmd_ready;
    busy        = (r_state == StLoad) || (r_state == StRun);
    done        = (r_state == StFinish);
    w_tick_term = (r_tick == TickMax);
    w_total     = (r_op == 2'b11) ? {r_count, 1'b0} : {1'b0, r_count};
    unique case (r_op)
      2'b01:   w_run_dir = 2'b01;
      2'b10:   w_run_dir = 2'b10;
      // Bounce: left for the first N steps, right for the remaining N
      2'b11:   w_run_dir = (r_step < {1'b0, r_count}) ? 2'b10 : 2'b01;
      default: w_run_dir = 2'b00;
    endcase
  end

  // Serial inputs: close the rotate loop from Q, or inject the fill bit; quiet outside RUN
  always_comb begin
    SR = 1'b0;
    SL = 1'b0;
    if (r_state == StRun) begin
      SR = r_fill ? r_fill_bit : Q[0];
      SL = r_fill ? r_fill_bit : Q[3];
    end
  end

  // Next-state logic; S is registered, so a step's mode is set up one cycle early
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_step_nxt  = r_step;
    w_s_nxt     = 2'b00;
    w_pdata_nxt = PData;
    unique case (r_state)
      StIdle, StFinish: begin
        w_state_nxt = StIdle;
        w_tick_nxt  = '0;
        w_step_nxt  = '0;
        if (w_accept) begin
          if (cmd_op == 2'b00) begin
            w_state_nxt = StLoad;
            w_s_nxt     = 2'b11;
            w_pdata_nxt = cmd_data;
          end else if (cmd_count == 4'd0) begin
            w_state_nxt = StFinish;
          end else begin
            w_state_nxt = StRun;
            // The tick counter idles at 0, so this cycle is tick 0. With TICK_DIV == 1 the
            // accept cycle is already terminal and step 1 must be set up now. Bounce
            // starts left.
            if (w_tick_term) begin
              w_s_nxt    = (cmd_op == 2'b01) ? 2'b01 : 2'b10;
              w_step_nxt = 5'd1;
              w_tick_nxt = '0;
            end else begin
              w_tick_nxt = TickW'(1);
            end
          end
        end
      end
      StLoad: begin
        w_state_nxt = StFinish;
      end
      StRun: begin
        if (r_step == w_total) begin
          w_state_nxt = StFinish;
          w_tick_nxt  = '0;
        end else begin
          w_tick_nxt = w_tick_term ? '0 : r_tick + TickW'(1);
          if (w_tick_term) begin
            w_s_nxt    = w_run_dir;
            w_step_nxt = r_step + 5'd1;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State, counters, registered register controls and the latched command
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state    <= StIdle;
      r_tick     <= '0;
      r_step     <= '0;
      r_op       <= 2'b00;
      r_count    <= 4'd0;
      r_fill     <= 1'b0;
      r_fill_bit <= 1'b0;
      S          <= 2'b00;
      PData      <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_step  <= w_step_nxt;
      S       <= w_s_nxt;
      PData   <= w_pdata_nxt;
      if (w_accept) begin
        r_op       <= cmd_op;
        r_count    <= cmd_count;
        r_fill     <= cmd_fill;
        r_fill_bit <= cmd_fill_bit;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl. It runs two controllers, one with TICK_DIV=1 and one with
// TICK_DIV=4. Each drives its own behavioural 74194-style register, and Q is fed back
// from that register.
module tb_shift_reg_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       valid1, valid4;
  logic [1:0] op;
  logic [3:0] data, count;
  logic       fill, fb;
  logic       ready1, ready4;
  logic [3:0] q1, q4, pd1, pd4;
  logic [1:0] s1, s4;
  logic       sr1, sl1, busy1, done1;
  logic       sr4, sl4, busy4, done4;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .clear(clear), .cmd_valid(valid1), .cmd_ready(ready1), .cmd_op(op),
    .cmd_data(data), .cmd_count(count), .cmd_fill(fill), .cmd_fill_bit(fb), .Q(q1),
    .S(s1), .PData(pd1), .SR(sr1), .SL(sl1), .busy(busy1), .done(done1)
  );

  shift_reg_ctrl #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .clear(clear), .cmd_valid(valid4), .cmd_ready(ready4), .cmd_op(op),
    .cmd_data(data), .cmd_count(count), .cmd_fill(fill), .cmd_fill_bit(fb), .Q(q4),
    .S(s4), .PData(pd4), .SR(sr4), .SL(sl4), .busy(busy4), .done(done4)
  );

  // Register models: right moves toward Q[0] with SR entering Q[3]; left moves toward Q[3]
  always @(posedge clk) begin
    if (clear) q1 <= 4'd0;
    else case (s1)
      2'b01: q1 <= {sr1, q1[3:1]};
      2'b10: q1 <= {q1[2:0], sl1};
      2'b11: q1 <= pd1;
      default: q1 <= q1;
    endcase
  end

  always @(posedge clk) begin
    if (clear) q4 <= 4'd0;
    else case (s4)
      2'b01: q4 <= {sr4, q4[3:1]};
      2'b10: q4 <= {q4[2:0], sl4};
      2'b11: q4 <= pd4;
      default: q4 <= q4;
    endcase
  end

  task automatic issue(input bit sel4, input logic [1:0] o, input logic [3:0] d,
                       input logic [3:0] n, input logic f, input logic b);
    op = o; data = d; count = n; fill = f; fb = b;
    if (sel4) valid4 = 1'b1;
    else valid1 = 1'b1;
  endtask

  task automatic load_quiet(input bit sel4, input logic [3:0] d);
    issue(sel4, 2'b00, d, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    valid1 = 1'b0; valid4 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    clear = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
    op = 2'b00; data = 4'd0; count = 4'd0; fill = 1'b0; fb = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ready1 !== 1'b0 || ready4 !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b%b want=00", ready1, ready4);
    end
    total++;
    if ({s1, s4, pd1, pd4} !== 12'h000) begin
      bad++; $display("FAIL reset_s_pdata got=%h want=000", {s1, s4, pd1, pd4});
    end
    total++;
    if ({busy1, done1, busy4, done4} !== 4'b0000) begin
      bad++; $display("FAIL reset_busy_done got=%b want=0000", {busy1, done1, busy4, done4});
    end
    clear = 1'b0;
    @(negedge clk);
    total++;
    if (ready1 !== 1'b1 || ready4 !== 1'b1) begin
      bad++; $display("FAIL reset_ready_after got=%b%b want=11", ready1, ready4);
    end
  endtask

  task automatic test_load();
    issue(1'b0, 2'b00, 4'b1011, 4'd0, 1'b0, 1'b0);
    total++;
    if (ready1 !== 1'b1) begin bad++; $display("FAIL load_ready got=%b want=1", ready1); end
    @(negedge clk);
    valid1 = 1'b0;
    total++;
    if (s1 !== 2'b11 || busy1 !== 1'b1 || done1 !== 1'b0) begin
      bad++; $display("FAIL load_k1 got s=%b busy=%b done=%b want s=11 busy=1 done=0",
                      s1, busy1, done1);
    end
    @(negedge clk);
    total++;
    if (q1 !== 4'b1011 || done1 !== 1'b1 || busy1 !== 1'b0 || s1 !== 2'b00) begin
      bad++; $display("FAIL load_k2 got q=%b done=%b busy=%b s=%b want q=1011 done=1 busy=0 s=00",
                      q1, done1, busy1, s1);
    end
    @(negedge clk);
    total++;
    if (done1 !== 1'b0) begin bad++; $display("FAIL load_k3_done got=%b want=0", done1); end
  endtask

  task automatic test_rotate_right();
    logic [3:0] qexp [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0100};
    load_quiet(1'b0, 4'b1000);
    issue(1'b0, 2'b01, 4'd0, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    valid1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      total++;
      if (q1 !== qexp[c-1]) begin
        bad++; $display("FAIL rotr_q c=%0d got=%b want=%b", c, q1, qexp[c-1]);
      end
      total++;
      if (s1 !== ((c <= 5) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL rotr_s c=%0d got=%b want=%b", c, s1, (c <= 5) ? 2'b01 : 2'b00);
      end
      total++;
      if (done1 !== (c == 6)) begin
        bad++; $display("FAIL rotr_done c=%0d got=%b want=%b", c, done1, c == 6);
      end
      if (c == 2) begin
        // Q = 0100 here, so rotate feeds SR = Q[0] = 0 and SL = Q[3] = 0
        total++;
        if (sr1 !== 1'b0 || sl1 !== 1'b0) begin
          bad++; $display("FAIL rotr_serial got=%b%b want=00", sr1, sl1);
        end
      end
    end
  endtask

  task automatic test_fill_left();
    load_quiet(1'b1, 4'b0000);
    issue(1'b1, 2'b10, 4'd0, 4'd3, 1'b1, 1'b1);
    @(negedge clk);
    valid4 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge clk);
      total++;
      if (s4 !== ((c == 4 || c == 8 || c == 12) ? 2'b10 : 2'b00)) begin
        bad++; $display("FAIL fill_s c=%0d got=%b", c, s4);
      end
      total++;
      if (done4 !== (c == 13)) begin
        bad++; $display("FAIL fill_done c=%0d got=%b want=%b", c, done4, c == 13);
      end
      if (c == 2) begin
        total++;
        if (sr4 !== 1'b1 || sl4 !== 1'b1) begin
          bad++; $display("FAIL fill_serial got=%b%b want=11", sr4, sl4);
        end
      end
      if (c == 9) begin
        total++;
        if (q4 !== 4'b0011) begin bad++; $display("FAIL fill_q_mid got=%b want=0011", q4); end
      end
      if (c == 13) begin
        total++;
        if (q4 !== 4'b0111) begin bad++; $display("FAIL fill_q_end got=%b want=0111", q4); end
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] qexp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0100, 4'b0010, 4'b0001, 4'b0001};
    logic [1:0] sexp [8] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    load_quiet(1'b0, 4'b0001);
    issue(1'b0, 2'b11, 4'd0, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    valid1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      total++;
      if (q1 !== qexp[c-1] || s1 !== sexp[c-1]) begin
        bad++; $display("FAIL bounce c=%0d got q=%b s=%b want q=%b s=%b",
                        c, q1, s1, qexp[c-1], sexp[c-1]);
      end
      total++;
      if (done1 !== (c == 7)) begin
        bad++; $display("FAIL bounce_done c=%0d got=%b want=%b", c, done1, c == 7);
      end
    end
  endtask

  task automatic test_zero_count();
    issue(1'b0, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    valid1 = 1'b0;
    total++;
    if (done1 !== 1'b1 || s1 !== 2'b00 || busy1 !== 1'b0 || sr1 !== 1'b0) begin
      bad++; $display("FAIL zero_k1 got done=%b s=%b busy=%b sr=%b want done=1 s=00 busy=0 sr=0",
                      done1, s1, busy1, sr1);
    end
    @(negedge clk);
    total++;
    if (q1 !== 4'b0001 || done1 !== 1'b0) begin
      bad++; $display("FAIL zero_k2 got q=%b done=%b want q=0001 done=0", q1, done1);
    end
  endtask

  task automatic test_clear_mid();
    int hits;
    issue(1'b0, 2'b01, 4'd0, 4'd10, 1'b0, 1'b0);
    @(negedge clk);
    valid1 = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    total++;
    if (ready1 !== 1'b0 || s1 !== 2'b00 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++; $display("FAIL clear_mid got ready=%b s=%b busy=%b done=%b want 0 00 0 0",
                      ready1, s1, busy1, done1);
    end
    clear = 1'b0;
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (s1 !== 2'b00 || done1 !== 1'b0 || busy1 !== 1'b0 || ready1 !== 1'b1) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++; $display("FAIL clear_after got=%0d bad cycles want=0", hits);
    end
    total++;
    if (q1 !== 4'b0000) begin bad++; $display("FAIL clear_q got=%b want=0000", q1); end
  endtask

  task automatic test_back_to_back();
    load_quiet(1'b0, 4'b1000);
    issue(1'b0, 2'b01, 4'd0, 4'd2, 1'b0, 1'b0);
    total++;
    if (ready1 !== 1'b1) begin bad++; $display("FAIL b2b_ready_a got=%b want=1", ready1); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      // Second command held on the bus from the first busy cycle on
      if (c == 1) issue(1'b0, 2'b00, 4'b0110, 4'd0, 1'b0, 1'b0);
      total++;
      if (ready1 !== (c == 3) || done1 !== (c == 3)) begin
        bad++; $display("FAIL b2b_hs c=%0d got ready=%b done=%b want=%b", c, ready1, done1,
                        c == 3);
      end
    end
    @(negedge clk);
    valid1 = 1'b0;
    total++;
    if (s1 !== 2'b11 || q1 !== 4'b0010) begin
      bad++; $display("FAIL b2b_load got s=%b q=%b want s=11 q=0010", s1, q1);
    end
    @(negedge clk);
    total++;
    if (q1 !== 4'b0110 || done1 !== 1'b1) begin
      bad++; $display("FAIL b2b_end got q=%b done=%b want q=0110 done=1", q1, done1);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_rotate_right();
    test_fill_left();
    test_bounce();
    test_zero_count();
    test_clear_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
